stack_tos_ctrl: RTL and testbench

- Upstream controller for the RAM-backed data/return stack in the microForth core.
- Holds top-of-stack (T) in a register and presents next-on-stack (N) from the RAM stack's read port.
- Translates core stack ops into the RAM stack's we/delta/wd protocol.
- Tracks depth and flags overflow/underflow.

---
 rtl/stack_pkg.sv | 22 ++
 rtl/stack_depth_ctr.sv | 63 ++++++
 rtl/stack_tos_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_stack_tos_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared op, RAM delta and SWAP state encodings for the stack TOS controller
package stack_pkg;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_DROP    = 3'd2;
    localparam logic [2:0] OP_POPREP  = 3'd3;
    localparam logic [2:0] OP_REPLACE = 3'd4;
    localparam logic [2:0] OP_SWAP    = 3'd5;

    localparam logic [1:0] DELTA_HOLD = 2'b00;
    localparam logic [1:0] DELTA_PUSH = 2'b01;
    localparam logic [1:0] DELTA_POP  = 2'b11;

    // ST_SWAP_POP is the cycle the SWAP is accepted; only SWAP_PUSH is a held state
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SWAP_POP  = 2'd1,
        ST_SWAP_PUSH = 2'd2
    } swap_state_t;

endpackage

// File: rtl/stack_depth_ctr.sv
// rtl/stack_depth_ctr.sv - logical depth counter with full/empty/ge2 compares and sticky ovf/unf flags
module stack_depth_ctr #(
    parameter int CAP = 512,
    parameter int DW  = $clog2(CAP + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_dec,
    input  logic          i_set_ovf,
    input  logic          i_set_unf,
    input  logic          i_err_clr,
    output logic [DW-1:0] o_depth,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_ge2,
    output logic          o_ovf,
    output logic          o_unf
);

    logic [DW-1:0] r_depth;
    logic          r_ovf;
    logic          r_unf;

    assign o_depth = r_depth;
    assign o_full  = (r_depth == DW'(CAP));
    assign o_empty = (r_depth == '0);
    // widened by one bit so the constant 2 survives when CAP is 1
    assign o_ge2   = ({1'b0, r_depth} >= (DW + 1)'(2));
    assign o_ovf   = r_ovf;
    assign o_unf   = r_unf;

    // depth moves by at most one per cycle and is blocked at both ends
    always_ff @(posedge clk) begin
        if (rst) begin
            r_depth <= '0;
        end else if (i_inc && !o_full) begin
            r_depth <= r_depth + 1'b1;
        end else if (i_dec && !o_empty) begin
            r_depth <= r_depth - 1'b1;
        end
    end

    // sticky error flags; a new error in the clear cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (i_set_ovf) begin
                r_ovf <= 1'b1;
            end else if (i_err_clr) begin
                r_ovf <= 1'b0;
            end
            if (i_set_unf) begin
                r_unf <= 1'b1;
            end else if (i_err_clr) begin
                r_unf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stack_tos_ctrl.sv
// rtl/stack_tos_ctrl.sv - top-of-stack register and op translator in front of the RAM stack
module stack_tos_ctrl
    import stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 512,
    parameter int CAP   = DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_valid,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           tos,
    output logic [WIDTH-1:0]           nos,
    output logic                       tos_valid,
    output logic                       nos_valid,
    output logic [$clog2(CAP+1)-1:0]   depth,
    output logic                       ovf,
    output logic                       unf,
    input  logic                       err_clr,
    output logic                       ram_we,
    output logic [1:0]                 ram_delta,
    output logic [WIDTH-1:0]           ram_wd,
    input  logic [WIDTH-1:0]           ram_rd
);

    localparam int DW      = $clog2(CAP + 1);
    // never let the logical capacity exceed what the RAM instance can hold
    localparam int CAP_EFF = (CAP < DEPTH) ? CAP : DEPTH;

    logic [WIDTH-1:0] r_tos;
    logic [WIDTH-1:0] r_shadow;
    swap_state_t      r_state;

    swap_state_t      w_phase;
    swap_state_t      w_state_nxt;
    logic [WIDTH-1:0] w_tos_nxt;
    logic [WIDTH-1:0] w_shadow_nxt;
    logic             w_we;
    logic [1:0]       w_delta;
    logic [WIDTH-1:0] w_wd;
    logic             w_inc;
    logic             w_dec;
    logic             w_set_ovf;
    logic             w_set_unf;
    logic             w_full;
    logic             w_empty;
    logic             w_ge2;
    logic [DW-1:0]    w_depth;

    stack_depth_ctr #(
        .CAP (CAP_EFF),
        .DW  (DW)
    ) u_depth (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (w_inc),
        .i_dec     (w_dec),
        .i_set_ovf (w_set_ovf),
        .i_set_unf (w_set_unf),
        .i_err_clr (err_clr),
        .o_depth   (w_depth),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_ge2     (w_ge2),
        .o_ovf     (ovf),
        .o_unf     (unf)
    );

    assign tos       = r_tos;
    assign nos       = ram_rd;
    assign depth     = w_depth;
    assign tos_valid = !w_empty;
    assign nos_valid = w_ge2;

    // reset forces the RAM command idle so the RAM pointer resets cleanly alongside us
    assign ram_we    = rst ? 1'b0 : w_we;
    assign ram_delta = rst ? DELTA_HOLD : w_delta;
    assign ram_wd    = rst ? r_tos : w_wd;

    // SWAP_POP is the accepting cycle itself, so the pop reaches the RAM without delay
    always_comb begin
        w_phase = r_state;
        if (r_state == ST_IDLE && op_valid && op == OP_SWAP && w_ge2) begin
            w_phase = ST_SWAP_POP;
        end
    end

    // op decode: RAM command, next T, depth step, error flags and SWAP sequencing
    always_comb begin
        w_state_nxt  = ST_IDLE;
        w_tos_nxt    = r_tos;
        w_shadow_nxt = r_shadow;
        w_we         = 1'b0;
        w_delta      = DELTA_HOLD;
        w_wd         = r_tos;
        w_inc        = 1'b0;
        w_dec        = 1'b0;
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;
        case (w_phase)
            ST_SWAP_POP: begin
                w_delta      = DELTA_POP;
                w_shadow_nxt = r_tos;
                w_tos_nxt    = ram_rd;
                w_state_nxt  = ST_SWAP_PUSH;
            end
            ST_SWAP_PUSH: begin
                w_we    = 1'b1;
                w_delta = DELTA_PUSH;
                w_wd    = r_shadow;
                // the core is not allowed to issue here; flag it and drop the op
                w_set_unf = op_valid;
            end
            default: begin
                if (op_valid) begin
                    case (op)
                        OP_PUSH: begin
                            if (w_full) begin
                                w_set_ovf = 1'b1;
                            end else if (w_empty) begin
                                w_tos_nxt = din;
                                w_inc     = 1'b1;
                            end else begin
                                w_we      = 1'b1;
                                w_delta   = DELTA_PUSH;
                                w_tos_nxt = din;
                                w_inc     = 1'b1;
                            end
                        end
                        OP_DROP: begin
                            if (w_empty) begin
                                w_set_unf = 1'b1;
                            end else if (!w_ge2) begin
                                w_dec = 1'b1;
                            end else begin
                                w_delta   = DELTA_POP;
                                w_tos_nxt = ram_rd;
                                w_dec     = 1'b1;
                            end
                        end
                        OP_POPREP: begin
                            if (!w_ge2) begin
                                w_set_unf = 1'b1;
                            end else begin
                                w_delta   = DELTA_POP;
                                w_tos_nxt = din;
                                w_dec     = 1'b1;
                            end
                        end
                        OP_REPLACE: begin
                            if (w_empty) begin
                                w_set_unf = 1'b1;
                            end else begin
                                w_tos_nxt = din;
                            end
                        end
                        OP_SWAP: begin
                            // a valid SWAP took the SWAP_POP branch, so only the short case lands here
                            w_set_unf = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        endcase
    end

    // SWAP state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // T and the SWAP shadow copy of the old T
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tos    <= '0;
            r_shadow <= '0;
        end else begin
            r_tos    <= w_tos_nxt;
            r_shadow <= w_shadow_nxt;
        end
    end

endmodule

// File: tb/tb_stack_tos_ctrl.sv
// tb/tb_stack_tos_ctrl.sv - directed vector bench for stack_tos_ctrl with a behavioural RAM stack
module tb_stack_tos_ctrl;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CAP   = 8;
    localparam int DW    = $clog2(CAP + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             op_valid = 1'b0;
    logic [2:0]       op = 3'd0;
    logic [WIDTH-1:0] din = '0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] tos, nos, ram_wd, ram_rd;
    logic             tos_valid, nos_valid, ovf, unf, ram_we;
    logic [DW-1:0]    depth;
    logic [1:0]       ram_delta;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stack_tos_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CAP(CAP)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .din(din),
        .tos(tos), .nos(nos), .tos_valid(tos_valid), .nos_valid(nos_valid),
        .depth(depth), .ovf(ovf), .unf(unf), .err_clr(err_clr),
        .ram_we(ram_we), .ram_delta(ram_delta), .ram_wd(ram_wd), .ram_rd(ram_rd)
    );

    // behavioural RAM stack: rd shows the top entry one cycle after push/pop
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [3:0]       sp;
    always @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (ram_we && ram_delta == 2'b01) begin
            mem[sp[2:0]] <= ram_wd;
            sp <= sp + 1'b1;
        end else if (ram_delta == 2'b11 && sp != 0) begin
            sp <= sp - 1'b1;
        end
    end
    logic [3:0] sp_m1;
    assign sp_m1  = sp - 1'b1;
    assign ram_rd = (sp == 0) ? '0 : mem[sp_m1[2:0]];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic             rst;
        logic             v;
        logic [2:0]       op;
        logic [15:0]      din;
        logic             clr;
        logic             e_we;
        logic [1:0]       e_delta;
        logic [15:0]      e_wd;
        logic [15:0]      e_tos;
        int               e_depth;
        logic             e_ovf;
        logic             e_unf;
        logic             c_nos;
        logic [15:0]      e_nos;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic [2:0] o, input logic [15:0] d, input logic c,
                       input logic we, input logic [1:0] dl, input logic [15:0] wd,
                       input logic [15:0] t, input int dp, input logic ov, input logic un,
                       input logic cn, input logic [15:0] n);
        vec_t x;
        x.rst = r; x.v = v; x.op = o; x.din = d; x.clr = c;
        x.e_we = we; x.e_delta = dl; x.e_wd = wd;
        x.e_tos = t; x.e_depth = dp; x.e_ovf = ov; x.e_unf = un; x.c_nos = cn; x.e_nos = n;
        vecs.push_back(x);
    endtask

    task automatic drive(input logic r, input logic v, input logic [2:0] o, input logic [15:0] d, input logic c);
        @(negedge clk);
        rst = r; op_valid = v; op = o; din = d; err_clr = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
        tick();
    endtask

    initial begin
        // establish a known T before the first vector looks at ram_wd
        repeat (2) @(posedge clk);

        //   rst v  op  din      clr we dl     wd        tos      dep ov un cn nos
        add(1, 0, 0, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0);
        add(0, 1, 1, 16'h0011, 0, 0, 2'b00, 16'h0000, 16'h0011, 1, 0, 0, 0, 16'h0);
        add(0, 1, 1, 16'h0022, 0, 1, 2'b01, 16'h0011, 16'h0022, 2, 0, 0, 1, 16'h0011);
        add(0, 1, 1, 16'h0033, 0, 1, 2'b01, 16'h0022, 16'h0033, 3, 0, 0, 1, 16'h0022);
        add(0, 1, 3, 16'h0055, 0, 0, 2'b11, 16'h0033, 16'h0055, 2, 0, 0, 1, 16'h0011);
        add(0, 1, 2, 16'h0000, 0, 0, 2'b11, 16'h0055, 16'h0011, 1, 0, 0, 0, 16'h0);
        add(0, 1, 2, 16'h0000, 0, 0, 2'b00, 16'h0011, 16'h0011, 0, 0, 0, 0, 16'h0);
        add(0, 1, 2, 16'h0000, 0, 0, 2'b00, 16'h0011, 16'h0011, 0, 0, 1, 0, 16'h0);
        add(0, 0, 0, 16'h0000, 1, 0, 2'b00, 16'h0011, 16'h0011, 0, 0, 0, 0, 16'h0);
        add(0, 1, 4, 16'h0077, 0, 0, 2'b00, 16'h0011, 16'h0011, 0, 0, 1, 0, 16'h0);
        add(0, 1, 2, 16'h0000, 1, 0, 2'b00, 16'h0011, 16'h0011, 0, 0, 1, 0, 16'h0);
        add(0, 1, 7, 16'h0000, 1, 0, 2'b00, 16'h0011, 16'h0011, 0, 0, 0, 0, 16'h0);
        add(0, 1, 1, 16'h1234, 0, 0, 2'b00, 16'h0011, 16'h1234, 1, 0, 0, 0, 16'h0);
        add(0, 1, 3, 16'h0005, 0, 0, 2'b00, 16'h1234, 16'h1234, 1, 0, 1, 0, 16'h0);
        add(0, 1, 5, 16'h0000, 0, 0, 2'b00, 16'h1234, 16'h1234, 1, 0, 1, 0, 16'h0);
        add(0, 1, 4, 16'h4321, 1, 0, 2'b00, 16'h1234, 16'h4321, 1, 0, 0, 0, 16'h0);
        add(0, 0, 1, 16'hDEAD, 0, 0, 2'b00, 16'h4321, 16'h4321, 1, 0, 0, 0, 16'h0);
        add(0, 1, 2, 16'h0000, 0, 0, 2'b00, 16'h4321, 16'h4321, 0, 0, 0, 0, 16'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].op, vecs[i].din, vecs[i].clr);
            chk("v_ram_we", i, 32'(ram_we), 32'(vecs[i].e_we));
            chk("v_ram_delta", i, 32'(ram_delta), 32'(vecs[i].e_delta));
            chk("v_ram_wd", i, 32'(ram_wd), 32'(vecs[i].e_wd));
            tick();
            chk("v_tos", i, 32'(tos), 32'(vecs[i].e_tos));
            chk("v_depth", i, 32'(depth), 32'(vecs[i].e_depth));
            chk("v_tos_valid", i, 32'(tos_valid), 32'(vecs[i].e_depth >= 1));
            chk("v_nos_valid", i, 32'(nos_valid), 32'(vecs[i].e_depth >= 2));
            chk("v_ovf", i, 32'(ovf), 32'(vecs[i].e_ovf));
            chk("v_unf", i, 32'(unf), 32'(vecs[i].e_unf));
            if (vecs[i].c_nos) chk("v_nos", i, 32'(nos), 32'(vecs[i].e_nos));
        end

        // fill to capacity, overflow once, then unwind in LIFO order
        do_reset();
        for (int i = 1; i <= CAP; i++) begin
            drive(1'b0, 1'b1, 3'd1, 16'(i), 1'b0);
            tick();
            chk("fill_depth", i, 32'(depth), 32'(i));
        end
        chk("fill_nos", CAP, 32'(nos), 32'(CAP - 1));
        drive(1'b0, 1'b1, 3'd1, 16'hBEEF, 1'b0);
        chk("ovf_ram_we", 0, 32'(ram_we), 32'd0);
        chk("ovf_ram_delta", 0, 32'(ram_delta), 32'd0);
        tick();
        chk("ovf_flag", 0, 32'(ovf), 32'd1);
        chk("ovf_tos", 0, 32'(tos), 32'(CAP));
        chk("ovf_depth", 0, 32'(depth), 32'(CAP));
        for (int k = CAP; k >= 1; k--) begin
            chk("lifo_tos", k, 32'(tos), 32'(k));
            drive(1'b0, 1'b1, 3'd2, 16'h0, 1'b0);
            tick();
        end
        chk("lifo_depth", 0, 32'(depth), 32'd0);
        chk("lifo_ovf_sticky", 0, 32'(ovf), 32'd1);
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1);
        tick();
        chk("ovf_clr", 0, 32'(ovf), 32'd0);

        // SWAP with an illegal op in the push cycle
        do_reset();
        drive(1'b0, 1'b1, 3'd1, 16'hAAAA, 1'b0); tick();
        drive(1'b0, 1'b1, 3'd1, 16'hBBBB, 1'b0); tick();
        drive(1'b0, 1'b1, 3'd5, 16'h0, 1'b0);
        chk("swap_pop_delta", 0, 32'(ram_delta), 32'b11);
        chk("swap_pop_we", 0, 32'(ram_we), 32'd0);
        tick();
        chk("swap_mid_tos", 0, 32'(tos), 32'hAAAA);
        drive(1'b0, 1'b1, 3'd1, 16'h5555, 1'b0);
        chk("swap_push_we", 0, 32'(ram_we), 32'd1);
        chk("swap_push_delta", 0, 32'(ram_delta), 32'b01);
        chk("swap_push_wd", 0, 32'(ram_wd), 32'hBBBB);
        tick();
        chk("swap_tos", 0, 32'(tos), 32'hAAAA);
        chk("swap_nos", 0, 32'(nos), 32'hBBBB);
        chk("swap_depth", 0, 32'(depth), 32'd2);
        chk("swap_busy_unf", 0, 32'(unf), 32'd1);

        // reset landing in the SWAP push cycle
        drive(1'b0, 1'b1, 3'd5, 16'h0, 1'b1); tick();
        chk("swap2_tos", 0, 32'(tos), 32'hBBBB);
        chk("swap2_unf_clr", 0, 32'(unf), 32'd0);
        drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
        chk("rst_swap_we", 0, 32'(ram_we), 32'd0);
        chk("rst_swap_delta", 0, 32'(ram_delta), 32'd0);
        tick();
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        chk("rst_depth", 0, 32'(depth), 32'd0);
        chk("rst_tos", 0, 32'(tos), 32'd0);
        chk("rst_ovf", 0, 32'(ovf), 32'd0);
        chk("rst_unf", 0, 32'(unf), 32'd0);
        chk("rst_idle_we", 0, 32'(ram_we), 32'd0);
        chk("rst_idle_delta", 0, 32'(ram_delta), 32'd0);
        tick();
        chk("rst_fsm_idle_we", 0, 32'(ram_we), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
